// File: rtl/serializador.sv
// rtl/serializador.sv - byte-to-serial transmitter, MSB first, 2-entry buffer, framed by write_out
// Optional even-parity bit after each byte when SERIALIZADOR_PARITY_EN is defined.
module serializador #(
  parameter int unsigned FRAME_GAP = 1
) (
  input  logic       clk_100KHz,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load_in,
  output logic       ready_out,
  input  logic       hold_in,
  output logic       data_out,
  output logic       write_out,
  output logic       busy_out,
  output logic [7:0] frames_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_PAR,
    ST_GAP
  } state_t;

  localparam logic [3:0] GAP_INIT = 4'(FRAME_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        data_q, data_d;
  logic        write_q, write_d;
  logic [7:0]  frames_q, frames_d;
  logic        push, pop, can_start;
  logic [7:0]  head;
`ifdef SERIALIZADOR_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign ready_out  = reset & (count_q != 2'd2);
  assign push       = load_in & ready_out;
  assign head       = fifo_q[rd_ptr_q];
  assign can_start  = (count_q != 2'd0) & ~hold_in;
  assign data_out   = data_q;
  assign write_out  = write_q;
  assign busy_out   = (state_q != ST_IDLE);
  assign frames_out = frames_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = 1'b0;
    write_d   = 1'b0;
    frames_d  = frames_q;
    pop       = 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (can_start) pop = 1'b1;
      end
      ST_SEND: begin
        // data_out always mirrors shift_q[7] while sending
        if (bit_cnt_q != 3'd0) begin
          shift_d   = {shift_q[6:0], 1'b0};
          data_d    = shift_q[6];
          write_d   = 1'b1;
          bit_cnt_d = bit_cnt_q - 3'd1;
        end else begin
`ifdef SERIALIZADOR_PARITY_EN
          state_d = ST_PAR;
          data_d  = parity_q;
          write_d = 1'b1;
`else
          state_d   = ST_GAP;
          frames_d  = frames_q + 8'd1;
          gap_cnt_d = GAP_INIT;
`endif
        end
      end
`ifdef SERIALIZADOR_PARITY_EN
      ST_PAR: begin
        state_d   = ST_GAP;
        frames_d  = frames_q + 8'd1;
        gap_cnt_d = GAP_INIT;
      end
`endif
      ST_GAP: begin
        if (gap_cnt_q != 4'd0) gap_cnt_d = gap_cnt_q - 4'd1;
        else if (can_start)    pop = 1'b1;
        else                   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame start: shared by the IDLE and GAP-exit paths
    if (pop) begin
      state_d   = ST_SEND;
      shift_d   = head;
      bit_cnt_d = 3'd7;
      data_d    = head[7];
      write_d   = 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
      parity_d  = ^head;
`endif
    end
  end

  always_ff @(posedge clk_100KHz) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      gap_cnt_q <= 4'd0;
      data_q    <= 1'b0;
      write_q   <= 1'b0;
      frames_q  <= 8'd0;
`ifdef SERIALIZADOR_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      write_q   <= write_d;
      frames_q  <= frames_d;
`ifdef SERIALIZADOR_PARITY_EN
      parity_q  <= parity_d;
`endif
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_100KHz) begin
    if (push) fifo_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: doc/serializador.md
# serializador

Parallel-to-serial transmitter and counterpart of the deserializer. Accepts 8-bit bytes through a valid/ready handshake into a 2-entry holding buffer and shifts each byte out MSB-first on a 1-bit line, framed by a `write_out` strobe. `data_out`/`write_out` drive a deserializer's `data_in`/`write_in`, and the far side's busy indication drives `hold_in`. Runs in the 100 kHz domain produced by the divider.

## Interface
- `FRAME_GAP`, default 1: number of idle cycles (`write_out`=0) inserted after every frame; legal range 1..15.
- `clk_100KHz`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `data_in`  in  8  byte to transmit.
- `load_in`  in  1  load request; the byte is accepted on an edge where `load_in`=1 and `ready_out`=1.
- `ready_out`  out  1  buffer has a free entry: (count < 2); forced 0 while `reset`=0.
- `hold_in`  in  1  far side busy; blocks the start of a new frame.
- `data_out`  out  1  serial data, registered.
- `write_out`  out  1  frame strobe, registered; 1 exactly while frame bits are on `data_out`.
- `busy_out`  out  1  1 whenever the FSM is not in IDLE.
- `frames_out`  out  8  completed-frame counter.

## Operation
- Buffer: 2-entry FIFO with an occupancy count of 0..2. A push occurs on accept. A pop occurs when the FSM loads the shift register.
  - Push and pop on the same edge: count unchanged, order preserved.
  - A load while full is ignored, because `ready_out`=0 at that point.
- FSM states: IDLE, SEND, PAR (only when compiled in), GAP.
  - IDLE -> SEND when count>0 and `hold_in`=0: pop the head into an 8-bit shift register and set the bit counter to 7.
  - SEND: `data_out`=shift[7], `write_out`=1. Shift left each cycle. After the 8th bit: go to PAR if enabled, otherwise to GAP.
  - PAR: `data_out`=parity bit, `write_out`=1, next state GAP.
  - GAP: `write_out`=0, `data_out`=0. Lasts `FRAME_GAP` cycles. On entry, increment `frames_out`, which wraps 255->0.
    - At the end of GAP, go to SEND directly if count>0 and `hold_in`=0, otherwise go to IDLE.
- `hold_in` is evaluated only at the IDLE/GAP-exit decision. Once a frame has started, it runs to completion regardless of `hold_in`.
- Reset (`reset`=0 on an edge), including mid-frame:
  - Buffer emptied and FSM returns to IDLE.
  - `data_out`=0, `write_out`=0, `busy_out`=0, `frames_out`=0.
  - The aborted frame is not counted.

## Timing
- Reset values: `data_out` 0, `write_out` 0, `busy_out` 0, `frames_out` 0. `ready_out` is 0 during reset and 1 on the first cycle after `reset` returns to 1.
- Frame start latency from an idle, empty block: a byte accepted at edge N moves the FSM to SEND at edge N+1. Bit 7 is valid from edge N+1 to edge N+2.
- Bit i (7..0) is held for exactly one clock. The frame occupies 8 cycles, or 9 with parity.
- Back-to-back frames: the period is 8+`FRAME_GAP` cycles, or 9+`FRAME_GAP` with parity.
- `write_out` never stays high across a frame boundary.
- `busy_out` rises at edge N+1 and falls on the edge where the FSM enters IDLE.

## Configuration
- Macro: `SERIALIZADOR_PARITY_EN`.
  - Defined: the PAR state exists. One extra bit, even parity (XOR of the 8 data bits), is sent with `write_out`=1 immediately after bit 0.
  - Undefined: PAR is removed, frames are exactly 8 bits, and all other behaviour is identical.

## Test plan
- **Single byte:** after reset, load 0xA5 at edge N.
  - `write_out`=1 for edges N+1..N+8 with `data_out` sequence 1,0,1,0,0,1,0,1.
  - Then `write_out`=0 for 1 cycle; `frames_out`=1.
- **Buffer full:** load 0x01, 0x02, 0x03 on consecutive edges while the first frame is sending.
  - `ready_out` goes 0 after 0x03 is accepted.
  - A 4th load of 0xFF is ignored.
  - Output frames are 0x01, 0x02, 0x03 in order, each separated by a 1-cycle gap.
- **Hold:** `hold_in`=1 with 0x3C buffered.
  - No frame starts and `busy_out`=0.
  - Dropping `hold_in` at edge M gives `write_out`=1 from edge M+1.
  - Raising `hold_in` mid-frame does not truncate the frame (still 8 bits).
- **Reset mid-frame:** assert `reset`=0 after bit 3 of 0xF0 with one byte queued.
  - Next edge: `write_out`=0, `data_out`=0, `frames_out`=0.
  - After release, `ready_out`=1 and no residual frame is sent.
- **Parity (macro defined):** send 0x07 -> 9th bit =1. Send 0x03 -> 9th bit =0.
- **Counter wrap:** send 256 frames -> `frames_out` returns to 0x00. Also check simultaneous load and pop at count=1 keeps count at 1.
